pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
- Sequential PC and fetch controller sitting on the other side of the next-PC selector.
- Holds the architectural PC and drives it, plus PC+4, to the jump selector and instruction memory.
- Takes the selected next PC back and fetches through a ready-handshake instruction-memory port.
- Generates the $ra link write for jal and counts retired instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, redirect target on misaligned next PC (optional feature only).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- next_pc  input  32  selected next PC from the jump selector.
- jump_sel  input  2  control jump code: 11 j, 10 jr, 01 jal, 00 branch/sequential.
- stall  input  1  pipeline hold; blocks PC advance.
- imem_ready  input  1  instruction memory has data on imem_rdata.
- imem_rdata  input  32  instruction word.
- pc_out  output  32  current PC (to selector pc input and imem address).
- pc_plus4  output  32  pc_out + 4, modulo 2^32.
- imem_req  output  1  fetch request.
- instr  output  32  latched instruction.
- instr_valid  output  1  instr is valid for decode.
- link_we  output  1  register-file write strobe for $ra.
- link_addr  output  5  constant 5'd31.
- link_data  output  32  PC+4 of the jal being retired.
- retire_cnt  output  32  retired instruction count.
- misaligned  output  1  misaligned next-PC pulse (optional feature).
- bad_pc  output  32  offending next_pc (optional feature).

Behaviour:
- Reset (asynchronous, reset_n=0) forces the following immediately:
  - pc_out=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, link_we=0, link_data=0.
  - retire_cnt=0, misaligned=0, bad_pc=0, state=IDLE.
- Reset asserted in any state aborts an outstanding fetch; a late imem_ready is ignored.
- pc_plus4 is combinational from pc_out; 32'hFFFF_FFFC wraps to 32'h0000_0000.
- IDLE:
  - Exactly one cycle after reset release, imem_req=0.
  - Next state is FETCH.
- FETCH:
  - imem_req=1, address=pc_out.
  - imem_ready=1 samples imem_rdata into instr; next state is EXEC, with instr_valid=1 from the next cycle.
  - imem_ready=0 holds FETCH indefinitely.
  - stall is ignored in FETCH.
- EXEC:
  - instr_valid=1, imem_req=0; imem_ready is ignored.
  - stall=1 holds the state; pc_out, instr and the counter are frozen.
  - stall=0 retires the instruction. Registered results, visible next cycle:
    - pc_out <= next_pc.
    - retire_cnt <= retire_cnt+1, wrapping at 2^32.
    - instr_valid <= 0; next state is FETCH.
  - On retire with jump_sel==01, link_we pulses for exactly one cycle with link_data = pc_plus4 of the retiring PC.
  - On retire with any other jump_sel, link_we=0.
- Minimum issue interval: 2 cycles per instruction (FETCH with ready=1, then EXEC with stall=0).
- next_pc is sampled only on the retire edge; changes during a stall have no effect.
- link_addr is always 5'd31.

Optional Feature:
- PC_ALIGN_CHECK_EN defined:
  - On retire with next_pc[1:0]!=0: pc_out <= EXC_VECTOR, bad_pc <= next_pc, misaligned pulses for one cycle, link_we is suppressed.
  - retire_cnt still increments.
- PC_ALIGN_CHECK_EN undefined:
  - pc_out <= {next_pc[31:2],2'b00}.
  - misaligned and bad_pc are tied 0.

Test Plan:
- Reset then sequential run: reset_n low 3 cycles, imem_ready=1, stall=0, next_pc=pc_plus4, jump_sel=00.
  - PC sequence 0,4,8,C at one retire every 2 cycles; retire_cnt=4 after 8 cycles.
- Memory wait: imem_ready held 0 for 5 cycles in FETCH.
  - imem_req stays 1, pc_out is unchanged, instr_valid=0.
  - Data 32'h2008_0005 is then captured; instr_valid=1 next cycle.
- Stall in EXEC: stall=1 for 4 cycles while next_pc toggles.
  - pc_out and retire_cnt are frozen.
  - On release, pc_out equals the next_pc present at the release edge.
- jal at PC 32'h0000_0040: jump_sel=01, next_pc=32'h0000_0100.
  - One-cycle link_we=1, link_addr=31, link_data=32'h0000_0044.
  - pc_out=32'h0000_0100.
- Reset mid-FETCH: reset_n=0 while imem_req=1, then imem_ready=1 during reset.
  - All outputs go to reset values immediately; no instr is captured.
  - IDLE runs one cycle after release.
- Wrap/alignment at pc_out=32'hFFFF_FFFC with next_pc=pc_plus4:
  - pc_out wraps to 0.
  - With PC_ALIGN_CHECK_EN and next_pc=32'h0000_0102: pc_out=32'h80, bad_pc=32'h102, misaligned pulses for one cycle.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// ============================================================================
// pc_fetch_unit : architectural PC holder, ready-handshake fetch, jal link, retire count
// Optional macro PC_ALIGN_CHECK_EN : trap misaligned next PC to EXC_VECTOR.  Rev 1.0
// ============================================================================
`default_nettype none

module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
`ifdef PC_ALIGN_CHECK_EN
   ,parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
`endif
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] next_pc,
   input  logic [1:0]  jump_sel,
   input  logic        stall,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        link_we,
   output logic [4:0]  link_addr,
   output logic [31:0] link_data,
   output logic [31:0] retire_cnt,
   output logic        misaligned,
   output logic [31:0] bad_pc
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2
   } state_t;

   localparam logic [1:0] C_JS_JAL = 2'b01;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        instr_valid_q, instr_valid_d;
   logic        imem_req_q, imem_req_d;
   logic        link_we_q, link_we_d;
   logic [31:0] link_data_q, link_data_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;
   logic [31:0] w_target_pc;
   logic        w_target_bad;
   logic [31:0] w_pc_plus4;

   assign w_pc_plus4 = pc_q + 32'd4;

`ifdef PC_ALIGN_CHECK_EN
   logic        misaligned_q, misaligned_d;
   logic [31:0] bad_pc_q, bad_pc_d;

   assign w_target_bad = (next_pc[1:0] != 2'b00);
   assign w_target_pc  = w_target_bad ? EXC_VECTOR : next_pc;
`else
   // Without the trap the low bits are simply forced to word alignment.
   assign w_target_bad = 1'b0;
   assign w_target_pc  = next_pc & 32'hFFFF_FFFC;
`endif

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_d       = instr_q;
      instr_valid_d = instr_valid_q;
      imem_req_d    = imem_req_q;
      link_we_d     = 1'b0;
      link_data_d   = link_data_q;
      retire_cnt_d  = retire_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
      misaligned_d  = 1'b0;
      bad_pc_d      = bad_pc_q;
`endif
      case (state_q)
         ST_IDLE: begin
            state_d    = ST_FETCH;
            imem_req_d = 1'b1;
         end
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d       = imem_rdata;
               instr_valid_d = 1'b1;
               imem_req_d    = 1'b0;
               state_d       = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (!stall) begin
               pc_d          = w_target_pc;
               retire_cnt_d  = retire_cnt_q + 32'd1;
               instr_valid_d = 1'b0;
               imem_req_d    = 1'b1;
               state_d       = ST_FETCH;
               if ((jump_sel == C_JS_JAL) && !w_target_bad) begin
                  link_we_d   = 1'b1;
                  link_data_d = w_pc_plus4;
               end
`ifdef PC_ALIGN_CHECK_EN
               if (w_target_bad) begin
                  misaligned_d = 1'b1;
                  bad_pc_d     = next_pc;
               end
`endif
            end
         end
         default: begin
            state_d    = ST_IDLE;
            imem_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         instr_q       <= 32'd0;
         instr_valid_q <= 1'b0;
         imem_req_q    <= 1'b0;
         link_we_q     <= 1'b0;
         link_data_q   <= 32'd0;
         retire_cnt_q  <= 32'd0;
`ifdef PC_ALIGN_CHECK_EN
         misaligned_q  <= 1'b0;
         bad_pc_q      <= 32'd0;
`endif
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         instr_valid_q <= instr_valid_d;
         imem_req_q    <= imem_req_d;
         link_we_q     <= link_we_d;
         link_data_q   <= link_data_d;
         retire_cnt_q  <= retire_cnt_d;
`ifdef PC_ALIGN_CHECK_EN
         misaligned_q  <= misaligned_d;
         bad_pc_q      <= bad_pc_d;
`endif
      end
   end

   assign pc_out      = pc_q;
   assign pc_plus4    = w_pc_plus4;
   assign imem_req    = imem_req_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign link_we     = link_we_q;
   assign link_addr   = 5'd31;
   assign link_data   = link_data_q;
   assign retire_cnt  = retire_cnt_q;
`ifdef PC_ALIGN_CHECK_EN
   assign misaligned  = misaligned_q;
   assign bad_pc      = bad_pc_q;
`else
   assign misaligned  = 1'b0;
   assign bad_pc      = 32'd0;
`endif

endmodule

`default_nettype wire
